serial_add16_ctrl: RTL and testbench

SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

---
 rtl/serial_add16_ctrl_pkg.sv | 13 +
 rtl/cla4.sv | 30 +++
 rtl/serial_add16_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add16_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add16_ctrl_pkg.sv
// Shared constants and FSM state type for the time-shared serial adder.
package serial_add16_ctrl_pkg;

    localparam int unsigned SLICE_W    = 4;
    localparam int unsigned DEF_NSLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; also exposes the carry into bit 3 for overflow detection.
module cla4
    import serial_add16_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is flattened so its propagate chain uses only lower-order bits.
    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/serial_add16_ctrl.sv
// Serial adder: one shared 4-bit CLA slice processes one operand slice per RUN cycle, LSB first.
module serial_add16_ctrl
    import serial_add16_ctrl_pkg::*;
#(
    parameter int unsigned NSLICE = DEF_NSLICE
)
(
    input  logic                        CLOCK_50,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SLICE_W*NSLICE-1:0]   a,
    input  logic [SLICE_W*NSLICE-1:0]   b,
    input  logic                        cin,
    output logic                        ready,
    output logic                        done,
    output logic [SLICE_W*NSLICE-1:0]   sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int unsigned W  = SLICE_W * NSLICE;
    localparam int unsigned IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state;
    state_t             state_next;
    logic [IW-1:0]      idx;
    logic               carry_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;

    logic               accept;
    logic               run;
    logic               last;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               co_sl;
    logic               c3_sl;

    assign last = (idx == IW'(NSLICE - 1));

    // State register
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        run        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Select the current operand slice for the shared adder
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (idx == IW'(i)) begin
                a_sl = a_reg[i*SLICE_W +: SLICE_W];
                b_sl = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4 u_cla4 (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_reg),
        .s    (s_sl),
        .cout (co_sl),
        .c3   (c3_sl)
    );

    // Operand, carry, result and status registers
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            ready <= (state_next == ST_IDLE);
            done  <= (state_next == ST_DONE);
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
                sum       <= '0;
            end
            if (run) begin
                for (int i = 0; i < int'(NSLICE); i++) begin
                    if (idx == IW'(i)) begin
                        sum[i*SLICE_W +: SLICE_W] <= s_sl;
                    end
                end
                carry_reg <= co_sl;
                idx       <= last ? '0 : idx + IW'(1);
                if (last) begin
                    cout <= co_sl;
                    ovf  <= co_sl ^ c3_sl;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Directed, table-driven bench for serial_add16_ctrl (NSLICE=4, 16-bit operands).
module tb_serial_add16_ctrl;

    localparam int unsigned W = 16;

    logic         CLOCK_50 = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    serial_add16_ctrl #(.NSLICE(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; runs one operation with garbage on the inputs after acceptance.
    task automatic run_op(input string tag, input vec_t v);
        int k;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        start = 1'b1; a = v.a; b = v.b; cin = v.cin;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
        k = 1;
        while (!done && k < 20) begin
            @(negedge CLOCK_50);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd5);
        check({tag, "_sum"}, 32'(sum), 32'(v.s));
        check({tag, "_cout"}, 32'(cout), 32'(v.co));
        check({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
        @(negedge CLOCK_50);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready_post"}, 32'(ready), 32'd1);
        check({tag, "_sum_hold"}, 32'(sum), 32'(v.s));
    endtask

    initial begin
        int k;
        int seen;
        int acc;
        int didx;
        int last_done;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];
        logic [W-1:0] bb_s[3];

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[9] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;

        // First start goes in on the very edge after reset release
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Start pulsed during RUN with new operands must be ignored
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b0;
        k = 1;
        while (!done && k < 20) begin
            if (k == 2) check("busy_ready_low", 32'(ready), 32'd0);
            start = (k == 2 || k == 3) ? 1'b1 : 1'b0;
            a = 16'h0001; b = 16'h0001; cin = 1'b0;
            @(negedge CLOCK_50);
            k++;
        end
        start = 1'b0;
        check("busy_latency", 32'(k), 32'd5);
        check("busy_sum", 32'(sum), 32'h0000);
        check("busy_cout", 32'(cout), 32'd1);
        @(negedge CLOCK_50);
        check("busy_ready_post", 32'(ready), 32'd1);
        check("busy_sum_hold", 32'(sum), 32'h0000);
        @(negedge CLOCK_50);
        check("busy_no_accept", 32'(ready), 32'd1);

        // Reset in the second RUN cycle abandons the operation
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge CLOCK_50);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (done) seen = 1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        run_op("after_rst", vecs[5]);

        // Back-to-back with start held high; operands only valid at acceptance
        bb_a[0] = 16'h1234; bb_b[0] = 16'h4321; bb_s[0] = 16'h5555;
        bb_a[1] = 16'hFFFF; bb_b[1] = 16'h0001; bb_s[1] = 16'h0000;
        bb_a[2] = 16'h7FFF; bb_b[2] = 16'h0001; bb_s[2] = 16'h8000;
        acc = 0; didx = 0; last_done = 0;
        start = 1'b1; cin = 1'b0;
        for (int cyc = 0; cyc < 80 && didx < 3; cyc++) begin
            if (done) begin
                check($sformatf("b2b_sum%0d", didx), 32'(sum), 32'(bb_s[didx]));
                if (didx > 0) check($sformatf("b2b_gap%0d", didx), 32'(cyc - last_done), 32'd6);
                last_done = cyc;
                didx++;
            end
            if (ready) begin
                if (acc < 3) begin
                    a = bb_a[acc]; b = bb_b[acc];
                    acc++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = W'($urandom); b = W'($urandom);
            end
            @(negedge CLOCK_50);
        end
        start = 1'b0;
        check("b2b_done_count", 32'(didx), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
